// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline hold/flush controller:
//   - controller state encoding (RUN / STALL / IRQ_ENT)
//   - per-cycle pipeline action encoding used between decision and output logic
//   - default interrupt vector
//   - pipeline register bank indices
// Optional feature macro used by this slice: PIPE_CTRL_BUS_TIMEOUT_EN
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    STALL   = 2'd1,
    IRQ_ENT = 2'd2
  } state_t;

  // What the pipeline does this cycle; the output mapping expands it per bank.
  typedef enum logic [1:0] {
    ACT_FREEZE = 2'd0,  // everything held, no bubbles
    ACT_REDIR  = 2'd1,  // PC redirect, two bubbles into IF/ID and ID/EX
    ACT_LDUSE  = 2'd2,  // hold PC and IF/ID, bubble into ID/EX
    ACT_GO     = 2'd3   // normal advance
  } act_t;

  localparam logic [31:0] IRQ_VEC_DEF = 32'h0000_0010;

  localparam int STG_IFID = 0;
  localparam int STG_IDEX = 1;
  localparam int STG_EXWB = 2;

endpackage

// File: rtl/pipe_ctrl_wdog.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_wdog
// Bus-wait watchdog. Counts cycles spent stalled on the memory bus, saturating
// at all ones, and raises a sticky timeout flag when the count reaches all ones.
// Only built when PIPE_CTRL_BUS_TIMEOUT_EN is defined.
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   stall       in   controller currently in STALL
//   hold_mem    in   LSU bus not ready
//   bus_timeout out  sticky timeout flag (registered)
// -----------------------------------------------------------------------------
`ifdef PIPE_CTRL_BUS_TIMEOUT_EN
module pipe_ctrl_wdog #(
  parameter int TMO_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  input  logic hold_mem,
  output logic bus_timeout
);

  localparam logic [TMO_W-1:0] CNT_MAX = {TMO_W{1'b1}};
  localparam logic [TMO_W-1:0] CNT_ONE = {{(TMO_W-1){1'b0}}, 1'b1};

  logic [TMO_W-1:0] cnt_r;
  logic [TMO_W-1:0] cnt_nxt_s;
  logic             flag_r;

  // Next count: cleared outside STALL, saturating increment while waiting on memory.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (!stall) begin
      cnt_nxt_s = {TMO_W{1'b0}};
    end else if (hold_mem && (cnt_r != CNT_MAX)) begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Counter and sticky flag; the flag rises on the same edge the count saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r  <= {TMO_W{1'b0}};
      flag_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_nxt_s;
      flag_r <= flag_r | (cnt_nxt_s == CNT_MAX);
    end
  end

  assign bus_timeout = flag_r;

endmodule
`endif

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Central pipeline hold/flush controller. Arbitrates memory/multicycle stall,
// taken jumps, load-use hazards and interrupt entry into one per-cycle decision
// that drives the PC register and every pipeline register bank.
// Optional feature macro: PIPE_CTRL_BUS_TIMEOUT_EN (bus-wait watchdog).
// Ports:
//   clk, rst              system clock, synchronous active-high reset
//   jump_req, jump_addr   resolved taken branch/jump from EX and its target
//   hold_mem, hold_mul    LSU bus not ready / multicycle unit busy
//   load_use              ID load-use hazard
//   irq_req, irq_ack      level interrupt request / one-cycle entry pulse
//   pc_ce, pc_load, pc_next  PC enable, redirect select, redirect target
//   stage_ce, stage_flush per-bank capture enable / bubble insert
//   bus_timeout           sticky bus-wait watchdog flag
// -----------------------------------------------------------------------------
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int          NSTAGE  = 3,
  parameter logic [31:0] IRQ_VEC = IRQ_VEC_DEF,
  parameter int          TMO_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_req,
  input  logic [31:0]       jump_addr,
  input  logic              hold_mem,
  input  logic              hold_mul,
  input  logic              load_use,
  input  logic              irq_req,
  output logic              irq_ack,
  output logic              pc_ce,
  output logic              pc_load,
  output logic [31:0]       pc_next,
  output logic [NSTAGE-1:0] stage_ce,
  output logic [NSTAGE-1:0] stage_flush,
  output logic              bus_timeout
);

  state_t      state_r;
  state_t      state_nxt_s;
  logic        pend_r;
  logic        pend_nxt_s;
  logic [31:0] paddr_r;
  logic [31:0] paddr_nxt_s;
  logic        irq_ack_r;
  act_t        act_s;
  logic [31:0] redir_addr_s;
  logic        hold_s;

  assign hold_s = hold_mem | hold_mul;

  // Per-cycle decision: pipeline action, redirect target and next controller state.
  always_comb begin
    act_s        = ACT_FREEZE;
    redir_addr_s = 32'h0000_0000;
    state_nxt_s  = state_r;
    pend_nxt_s   = pend_r;
    paddr_nxt_s  = paddr_r;
    case (state_r)
      IRQ_ENT: begin
        act_s        = ACT_REDIR;
        redir_addr_s = IRQ_VEC;
        state_nxt_s  = RUN;
        // A jump resolving during entry is kept and replayed after the vector fetch.
        if (jump_req && !pend_r) begin
          pend_nxt_s  = 1'b1;
          paddr_nxt_s = jump_addr;
        end else begin
          pend_nxt_s  = pend_r;
        end
      end
      RUN, STALL: begin
        if (hold_s) begin
          act_s       = ACT_FREEZE;
          state_nxt_s = STALL;
          // EX is frozen once a jump is pending, so a later jump_req is a repeat.
          if (jump_req && !pend_r) begin
            pend_nxt_s  = 1'b1;
            paddr_nxt_s = jump_addr;
          end else begin
            pend_nxt_s  = pend_r;
          end
        end else begin
          state_nxt_s = RUN;
          if (pend_r) begin
            act_s        = ACT_REDIR;
            redir_addr_s = paddr_r;
            pend_nxt_s   = 1'b0;
          end else if (jump_req) begin
            act_s        = ACT_REDIR;
            redir_addr_s = jump_addr;
          end else if (load_use) begin
            act_s = ACT_LDUSE;
          end else if (irq_req && (state_r == RUN)) begin
            // Freeze this cycle so entry redirects from a quiet pipeline.
            act_s       = ACT_FREEZE;
            state_nxt_s = IRQ_ENT;
          end else begin
            act_s = ACT_GO;
          end
        end
      end
      default: begin
        act_s       = ACT_FREEZE;
        state_nxt_s = RUN;
        pend_nxt_s  = 1'b0;
      end
    endcase
  end

  // Expand the action into PC and per-bank enables; reset forces a safe frozen/flushed view.
  always_comb begin
    pc_ce       = 1'b0;
    pc_load     = 1'b0;
    pc_next     = 32'h0000_0000;
    stage_ce    = {NSTAGE{1'b0}};
    stage_flush = {NSTAGE{1'b0}};
    if (rst) begin
      stage_flush = {NSTAGE{1'b1}};
    end else begin
      case (act_s)
        ACT_REDIR: begin
          pc_ce                 = 1'b1;
          pc_load               = 1'b1;
          pc_next               = redir_addr_s;
          stage_ce              = {NSTAGE{1'b1}};
          stage_flush[STG_IFID] = 1'b1;
          stage_flush[STG_IDEX] = 1'b1;
          stage_flush[STG_EXWB] = 1'b0;
        end
        ACT_LDUSE: begin
          stage_ce              = {NSTAGE{1'b1}};
          stage_ce[STG_IFID]    = 1'b0;
          stage_flush[STG_IDEX] = 1'b1;
        end
        ACT_GO: begin
          pc_ce    = 1'b1;
          stage_ce = {NSTAGE{1'b1}};
        end
        ACT_FREEZE: begin
          pc_ce    = 1'b0;
          stage_ce = {NSTAGE{1'b0}};
        end
        default: begin
          pc_ce    = 1'b0;
          stage_ce = {NSTAGE{1'b0}};
        end
      endcase
    end
  end

  // Controller state, pending jump and the registered interrupt acknowledge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= RUN;
      pend_r    <= 1'b0;
      paddr_r   <= 32'h0000_0000;
      irq_ack_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      pend_r    <= pend_nxt_s;
      paddr_r   <= paddr_nxt_s;
      irq_ack_r <= (state_r == IRQ_ENT);
    end
  end

  assign irq_ack = irq_ack_r;

`ifdef PIPE_CTRL_BUS_TIMEOUT_EN
  pipe_ctrl_wdog #(
    .TMO_W (TMO_W)
  ) u_wdog (
    .clk         (clk),
    .rst         (rst),
    .stall       (state_r == STALL),
    .hold_mem    (hold_mem),
    .bus_timeout (bus_timeout)
  );
`else
  // Watchdog compiled out; TMO_W stays referenced so both builds share one interface.
  assign bus_timeout = 1'b0 & (TMO_W > 0);
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
// Self-checking bench for pipe_ctrl: directed scenarios followed by random
// stimulus, every cycle compared against a behavioural model of the controller.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_req;
  logic [31:0] jump_addr;
  logic        hold_mem;
  logic        hold_mul;
  logic        load_use;
  logic        irq_req;
  logic        irq_ack;
  logic        pc_ce;
  logic        pc_load;
  logic [31:0] pc_next;
  logic [2:0]  stage_ce;
  logic [2:0]  stage_flush;
  logic        bus_timeout;

  int n_checks = 0;
  int n_errors = 0;

  // Model: stalled/irq_entry describe where the controller is, pend/paddr the
  // deferred jump, ack the registered pulse, wd/tmo the watchdog.
  bit          m_stalled;
  bit          m_irq;
  bit          m_pend;
  logic [31:0] m_paddr;
  bit          m_ack;
  int          m_wd;
  bit          m_tmo;

  pipe_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .jump_req    (jump_req),
    .jump_addr   (jump_addr),
    .hold_mem    (hold_mem),
    .hold_mul    (hold_mul),
    .load_use    (load_use),
    .irq_req     (irq_req),
    .irq_ack     (irq_ack),
    .pc_ce       (pc_ce),
    .pc_load     (pc_load),
    .pc_next     (pc_next),
    .stage_ce    (stage_ce),
    .stage_flush (stage_flush),
    .bus_timeout (bus_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One cycle: drive inputs after the falling edge, compare, advance the model.
  task automatic step(input bit r, input bit jr, input logic [31:0] ja,
                      input bit hm, input bit hmu, input bit lu, input bit ir);
    bit          e_pcce, e_load;
    logic [31:0] e_next;
    logic [2:0]  e_ce, e_fl;
    bit          n_stalled, n_irq, n_pend, n_ack, n_tmo;
    logic [31:0] n_paddr;
    int          n_wd;
    @(negedge clk);
    rst = r; jump_req = jr; jump_addr = ja; hold_mem = hm; hold_mul = hmu;
    load_use = lu; irq_req = ir;
    #1;
    e_pcce = 1'b0; e_load = 1'b0; e_next = 32'h0; e_ce = 3'b000; e_fl = 3'b000;
    n_stalled = m_stalled; n_irq = 1'b0; n_pend = m_pend; n_paddr = m_paddr;
    n_ack = m_irq; n_wd = m_wd; n_tmo = m_tmo;
    if (r) begin
      e_fl = 3'b111;
      n_stalled = 1'b0; n_pend = 1'b0; n_ack = 1'b0; n_wd = 0; n_tmo = 1'b0;
    end else begin
      if (m_irq) begin
        e_pcce = 1'b1; e_load = 1'b1; e_next = 32'h0000_0010; e_ce = 3'b111; e_fl = 3'b011;
        n_stalled = 1'b0;
        if (jr && !m_pend) begin n_pend = 1'b1; n_paddr = ja; end
      end else if (hm || hmu) begin
        n_stalled = 1'b1;
        if (jr && !m_pend) begin n_pend = 1'b1; n_paddr = ja; end
      end else begin
        n_stalled = 1'b0;
        if (m_pend) begin
          e_pcce = 1'b1; e_load = 1'b1; e_next = m_paddr; e_ce = 3'b111; e_fl = 3'b011;
          n_pend = 1'b0;
        end else if (jr) begin
          e_pcce = 1'b1; e_load = 1'b1; e_next = ja; e_ce = 3'b111; e_fl = 3'b011;
        end else if (lu) begin
          e_ce = 3'b110; e_fl = 3'b010;
        end else if (ir && !m_stalled) begin
          n_irq = 1'b1;
        end else begin
          e_pcce = 1'b1; e_ce = 3'b111;
        end
      end
      // Watchdog counts memory-wait cycles spent in STALL, saturating at 255.
      if (!m_stalled) n_wd = 0;
      else if (hm) n_wd = (m_wd < 255) ? m_wd + 1 : 255;
      else n_wd = m_wd;
`ifdef PIPE_CTRL_BUS_TIMEOUT_EN
      n_tmo = m_tmo | (n_wd == 255);
`else
      n_tmo = 1'b0;
`endif
    end
    chk("pc_ce",       {31'd0, pc_ce},       {31'd0, e_pcce});
    chk("pc_load",     {31'd0, pc_load},     {31'd0, e_load});
    chk("pc_next",     pc_next,              e_next);
    chk("stage_ce",    {29'd0, stage_ce},    {29'd0, e_ce});
    chk("stage_flush", {29'd0, stage_flush}, {29'd0, e_fl});
    chk("irq_ack",     {31'd0, irq_ack},     {31'd0, m_ack});
    chk("bus_timeout", {31'd0, bus_timeout}, {31'd0, m_tmo});
    m_stalled = n_stalled; m_irq = n_irq; m_pend = n_pend; m_paddr = n_paddr;
    m_ack = n_ack; m_wd = n_wd; m_tmo = n_tmo;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic mem_hold(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; jump_req = 1'b0; jump_addr = 32'h0; hold_mem = 1'b0;
    hold_mul = 1'b0; load_use = 1'b0; irq_req = 1'b0;
    m_stalled = 1'b0; m_irq = 1'b0; m_pend = 1'b0; m_paddr = 32'h0;
    m_ack = 1'b0; m_wd = 0; m_tmo = 1'b0;
    // Unchecked first reset edge brings the registers out of X.
    @(posedge clk);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Jump in RUN, then normal.
    step(1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    // Load-use bubble.
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    // Jump during a 4-cycle memory stall, applied on release.
    step(1'b0, 1'b1, 32'h0000_0200, 1'b1, 1'b0, 1'b0, 1'b0);
    mem_hold(3);
    idle(2);
    // Interrupt entry and acknowledge pulse.
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(4);
    // Jump arriving during entry is replayed afterwards.
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0300, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);
    // Interrupt is not taken on stall release.
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    // Reset mid-stall drops the pending jump.
    step(1'b0, 1'b1, 32'h0000_0400, 1'b1, 1'b0, 1'b0, 1'b0);
    mem_hold(1);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    // Watchdog: 256 wait cycles trip it, 254 do not.
    mem_hold(256);
    idle(3);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    mem_hold(254);
    idle(3);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 20,
           $urandom,
           $urandom_range(0, 99) < 20,
           $urandom_range(0, 99) < 10,
           $urandom_range(0, 99) < 15,
           $urandom_range(0, 99) < 15);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
